// File: rtl/countdown_pkg.sv
// Shared types and BCD helpers for the MM:SS countdown core.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NIBBLE_MAX = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX   = 4'd5;

    // Saturate a {tens, units} BCD byte; tens_max is 9 for minutes, 5 for seconds.
    function automatic logic [7:0] bcd_clamp(input logic [7:0] value, input logic [3:0] tens_max);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = (value[7:4] > tens_max)       ? tens_max       : value[7:4];
        units = (value[3:0] > BCD_NIBBLE_MAX) ? BCD_NIBBLE_MAX : value[3:0];
        return {tens, units};
    endfunction

    // One-second decrement of {min_tens, min_units, sec_tens, sec_units}.
    // Caller guarantees the value is non-zero, so minute tens never underflows.
    function automatic logic [15:0] bcd_dec_mmss(input logic [15:0] mmss);
        logic [15:0] result;
        result = mmss;
        if (mmss[3:0] != 4'd0) begin
            result[3:0] = mmss[3:0] - 4'd1;
        end else begin
            result[3:0] = BCD_NIBBLE_MAX;
            if (mmss[7:4] != 4'd0) begin
                result[7:4] = mmss[7:4] - 4'd1;
            end else begin
                result[7:4] = SEC_TENS_MAX;
                if (mmss[11:8] != 4'd0) begin
                    result[11:8] = mmss[11:8] - 4'd1;
                end else begin
                    result[11:8]  = BCD_NIBBLE_MAX;
                    result[15:12] = mmss[15:12] - 4'd1;
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/countdown_core_if.sv
// Control/status bundle between the panel logic (master) and the countdown core (slave).
interface countdown_core_if;
    logic       tick_in;
    logic       load;
    logic       start_pause;
    logic [7:0] preset_min;
    logic [7:0] preset_sec;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       running;
    logic       done;
    logic       alarm;

    modport master (
        output tick_in, load, start_pause, preset_min, preset_sec,
        input  min_bcd, sec_bcd, running, done, alarm
    );

    modport slave (
        input  tick_in, load, start_pause, preset_min, preset_sec,
        output min_bcd, sec_bcd, running, done, alarm
    );
endinterface

// File: rtl/countdown_core_tick_sync_edge.sv
// Two-flop synchroniser plus an edge flop; emits one clock-wide pulse per rising edge of level_in.
module tick_sync_edge (
    input  logic clock,
    input  logic reset,
    input  logic level_in,
    output logic tick_pulse
);
    // sync_reg[0], sync_reg[1] form the synchroniser; sync_reg[2] remembers the previous level.
    logic [2:0] sync_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_reg <= 3'b000;
        end else begin
            sync_reg <= {sync_reg[1:0], level_in};
        end
    end

    assign tick_pulse = sync_reg[1] & ~sync_reg[2];
endmodule

// File: rtl/countdown_core.sv
// BCD MM:SS countdown with load, start/pause and a one-cycle alarm on reaching 00:00.
module countdown_core
    import countdown_pkg::*;
#(
    parameter logic [7:0] DEFAULT_MIN = 8'h05,
    parameter logic [7:0] DEFAULT_SEC = 8'h00
) (
    input  logic            clock,
    input  logic            reset,
    countdown_core_if.slave bus
);
    state_t      state_reg;
    state_t      state_next;
    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic [15:0] shadow_reg;
    logic [15:0] shadow_next;
    logic        alarm_reg;
    logic        alarm_next;
    logic        tick_pulse;
    logic        count_is_zero;
    logic        count_is_one;
    logic        running;
    logic        done;

    tick_sync_edge u_tick_sync (
        .clock      (clock),
        .reset      (reset),
        .level_in   (bus.tick_in),
        .tick_pulse (tick_pulse)
    );

    assign count_is_zero = (count_reg == 16'h0000);
    assign count_is_one  = (count_reg == 16'h0001);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.load) begin
            state_next = IDLE;
        end else if (bus.start_pause) begin
            unique case (state_reg)
                IDLE:  state_next = count_is_zero ? IDLE : RUN;
                // A pause landing on the final tick still finishes; pausing at 00:00 would strand the count.
                RUN:   state_next = (tick_pulse && count_is_one) ? DONE : PAUSE;
                PAUSE: state_next = RUN;
                DONE:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end else if (state_reg == RUN && tick_pulse && count_is_one) begin
            state_next = DONE;
        end
    end

    always_comb begin
        running = (state_reg == RUN);
        done    = (state_reg == DONE);
    end

    always_comb begin
        count_next  = count_reg;
        shadow_next = shadow_reg;
        if (bus.load) begin
            count_next  = {bcd_clamp(bus.preset_min, BCD_NIBBLE_MAX),
                           bcd_clamp(bus.preset_sec, SEC_TENS_MAX)};
            shadow_next = count_next;
        end else if (state_reg == DONE && bus.start_pause) begin
            count_next = shadow_reg;
        end else if (state_reg == RUN && tick_pulse) begin
            count_next = bcd_dec_mmss(count_reg);
        end
        alarm_next = (state_next == DONE) && (state_reg != DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_reg  <= {DEFAULT_MIN, DEFAULT_SEC};
            shadow_reg <= {DEFAULT_MIN, DEFAULT_SEC};
            alarm_reg  <= 1'b0;
        end else begin
            count_reg  <= count_next;
            shadow_reg <= shadow_next;
            alarm_reg  <= alarm_next;
        end
    end

    assign bus.min_bcd = count_reg[15:8];
    assign bus.sec_bcd = count_reg[7:0];
    assign bus.running = running;
    assign bus.done    = done;
    assign bus.alarm   = alarm_reg;
endmodule

// File: tb/tb_countdown_core.sv
// Directed bench for countdown_core: inputs driven on falling edges, outputs sampled on falling edges.
module tb_countdown_core;
    logic clock;
    logic reset;
    int   checks;
    int   failures;

    countdown_core_if cif ();

    countdown_core #(
        .DEFAULT_MIN (8'h05),
        .DEFAULT_SEC (8'h00)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (cif)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Compares {min, sec, running, done, alarm} against the expected snapshot.
    task automatic check_state(input string tag, input logic [15:0] mmss,
                               input logic run, input logic dn, input logic al);
        logic [18:0] obs;
        logic [18:0] exp;
        obs = {cif.min_bcd, cif.sec_bcd, cif.running, cif.done, cif.alarm};
        exp = {mmss, run, dn, al};
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed mmss=%h run=%b done=%b alarm=%b expected mmss=%h run=%b done=%b alarm=%b",
                   tag, obs[18:3], obs[2], obs[1], obs[0], exp[18:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic pulse_load(input logic [7:0] pmin, input logic [7:0] psec);
        cif.preset_min = pmin;
        cif.preset_sec = psec;
        cif.load = 1'b1;
        @(negedge clock);
        cif.load = 1'b0;
    endtask

    task automatic pulse_sp();
        cif.start_pause = 1'b1;
        @(negedge clock);
        cif.start_pause = 1'b0;
    endtask

    // Raise tick_in and wait until just after the edge that applies it.
    task automatic tick_rise();
        cif.tick_in = 1'b1;
        repeat (3) @(negedge clock);
    endtask

    task automatic tick_fall();
        cif.tick_in = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic full_tick();
        tick_rise();
        tick_fall();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        cif.tick_in = 1'b0;
        cif.load = 1'b0;
        cif.start_pause = 1'b0;
        cif.preset_min = 8'h00;
        cif.preset_sec = 8'h00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check_state("reset", 16'h0500, 1'b0, 1'b0, 1'b0);

        // Idle with tick_in toggling: the count must not move.
        for (int i = 0; i < 100; i++) begin
            cif.tick_in = ((i / 5) % 2) == 1;
            @(negedge clock);
            check_state("idle_hold", 16'h0500, 1'b0, 1'b0, 1'b0);
        end
        tick_fall();

        // 01:00 -> 00:59 on the third edge after the rise, then a held level.
        pulse_load(8'h01, 8'h00);
        check_state("load_0100", 16'h0100, 1'b0, 1'b0, 1'b0);
        pulse_sp();
        check_state("start_0100", 16'h0100, 1'b1, 1'b0, 1'b0);
        cif.tick_in = 1'b1;
        repeat (2) @(negedge clock);
        check_state("tick_edge2", 16'h0100, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        check_state("tick_edge3", 16'h0059, 1'b1, 1'b0, 1'b0);
        repeat (50) @(negedge clock);
        check_state("tick_held", 16'h0059, 1'b1, 1'b0, 1'b0);
        tick_fall();

        // 00:02 down to DONE, alarm for one cycle, re-arm from the shadow preset.
        pulse_load(8'h00, 8'h02);
        pulse_sp();
        full_tick();
        check_state("run_0001", 16'h0001, 1'b1, 1'b0, 1'b0);
        tick_rise();
        check_state("done_entry", 16'h0000, 1'b0, 1'b1, 1'b1);
        @(negedge clock);
        check_state("alarm_drop", 16'h0000, 1'b0, 1'b1, 1'b0);
        tick_fall();
        full_tick();
        check_state("done_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
        pulse_sp();
        check_state("rearm", 16'h0002, 1'b0, 1'b0, 1'b0);

        // Pause / resume from 00:30.
        pulse_load(8'h00, 8'h30);
        pulse_sp();
        repeat (3) full_tick();
        check_state("run_0027", 16'h0027, 1'b1, 1'b0, 1'b0);
        pulse_sp();
        check_state("paused", 16'h0027, 1'b0, 1'b0, 1'b0);
        repeat (5) full_tick();
        check_state("pause_hold", 16'h0027, 1'b0, 1'b0, 1'b0);
        pulse_sp();
        full_tick();
        check_state("resume_0026", 16'h0026, 1'b1, 1'b0, 1'b0);

        // start_pause on the same edge as a tick in RUN: decrement, then pause.
        cif.tick_in = 1'b1;
        repeat (2) @(negedge clock);
        pulse_sp();
        check_state("sp_tick_run", 16'h0025, 1'b0, 1'b0, 1'b0);
        tick_fall();

        // start_pause on the same edge as a tick in PAUSE: resume only.
        cif.tick_in = 1'b1;
        repeat (2) @(negedge clock);
        pulse_sp();
        check_state("sp_tick_pause", 16'h0025, 1'b1, 1'b0, 1'b0);
        tick_fall();

        // Load mid-run with out-of-range nibbles aborts and clamps.
        pulse_load(8'hA7, 8'h7C);
        check_state("load_clamp", 16'h9759, 1'b0, 1'b0, 1'b0);
        pulse_sp();
        full_tick();
        check_state("run_9758", 16'h9758, 1'b1, 1'b0, 1'b0);

        // Minute borrow boundary 10:00 -> 09:59.
        pulse_load(8'h10, 8'h00);
        pulse_sp();
        full_tick();
        check_state("borrow_1000", 16'h0959, 1'b1, 1'b0, 1'b0);

        // Reset in the middle of a run.
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_state("reset_midrun", 16'h0500, 1'b0, 1'b0, 1'b0);

        // start_pause at 00:00 in IDLE is ignored.
        pulse_load(8'h00, 8'h00);
        pulse_sp();
        check_state("zero_sp", 16'h0000, 1'b0, 1'b0, 1'b0);
        full_tick();
        check_state("zero_sp_hold", 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
